// File: rtl/i2c_pkg.sv
// Shared definitions for the SCCB/I2C byte-level master: FSM encodings and ack bit positions.
package i2c_pkg;

  typedef enum logic [3:0] {
    StIdle  = 4'd0,
    StStart = 4'd1,
    StWrBit = 4'd2,
    StWrAck = 4'd3,
    StRdBit = 4'd4,
    StRdAck = 4'd5,
    StStop  = 4'd6,
    StHold  = 4'd7
  } state_e;

  localparam int unsigned ACK_VALID = 1;
  localparam int unsigned ACK_OK    = 0;

endpackage

// File: rtl/i2c_qtick.sv
// Quarter-period tick generator: one-cycle tick every `period` clocks, held cleared by restart.
module i2c_qtick #(
  parameter int unsigned period = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CntW = (period > 1) ? $clog2(period) : 1;
  localparam logic [CntW-1:0] Last = CntW'(period - 1);

  logic [CntW-1:0] cnt_q;

  assign tick = !restart && (cnt_q == Last);

  always_ff @(posedge clk) begin
    if (!rst_n || restart || (cnt_q == Last)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/i2c_master.sv
// Open-drain I2C/SCCB byte master: START, byte write with ACK sample, byte read with ACK/NACK,
// STOP. Each SCL bit is four quarters: low, low, high, high.
module i2c_master
  import i2c_pkg::*;
#(
  parameter int unsigned main_clock = 143_000_000,
  parameter int unsigned freq       = 100_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic [7:0] wr_data,
  output logic       rd_tick,
  output logic [1:0] ack,
  output logic [7:0] rd_data,
  inout  wire        scl,
  inout  wire        sda,
  output logic [3:0] state
);

  localparam int unsigned Q = main_clock / (4 * freq);

  state_e      state_q, state_d, st_eff;
  logic [1:0]  phase_q, phase_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        rw_q, rw_d;
  logic        addr_q, addr_d;
  logic        nack_q, nack_d;
  logic        sda_s_q, sda_s_d;
  logic        scl_oe_q, scl_oe_d;
  logic        sda_oe_q, sda_oe_d;
  logic [1:0]  ack_q, ack_d;
  logic        rd_tick_q, rd_tick_d;
  logic [7:0]  rd_data_q, rd_data_d;
  logic        tick, qrestart, sda_in;

  assign qrestart = (state_q == StIdle);
  assign sda_in   = sda;

  i2c_qtick #(
    .period (Q)
  ) u_qtick (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (qrestart),
    .tick    (tick)
  );

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    rw_d      = rw_q;
    addr_d    = addr_q;
    nack_d    = nack_q;
    sda_s_d   = sda_s_q;
    scl_oe_d  = scl_oe_q;
    sda_oe_d  = sda_oe_q;
    ack_d     = 2'b00;
    rd_tick_d = 1'b0;
    rd_data_d = rd_data_q;

    // Controller decisions are taken in the cycle after the ack/rd_tick pulse is registered,
    // so stop/wr_data presented alongside the pulse are seen here.
    if (state_q == StIdle) begin
      scl_oe_d  = 1'b0;
      sda_oe_d  = 1'b0;
      phase_d   = 2'd0;
      bit_cnt_d = 3'd0;
      if (start) begin
        shreg_d = wr_data;
        rw_d    = wr_data[0];
        addr_d  = 1'b1;
        state_d = StStart;
      end
    end else if (state_q == StWrAck && ack_q[ACK_VALID]) begin
      bit_cnt_d = 3'd0;
      addr_d    = 1'b0;
      if (stop) begin
        state_d = StStop;
      end else if (addr_q && rw_q) begin
        state_d = StRdBit;
      end else begin
        shreg_d = wr_data;
        state_d = StWrBit;
      end
    end else if (state_q == StRdBit && rd_tick_q) begin
      nack_d    = stop;
      bit_cnt_d = 3'd0;
      state_d   = StRdAck;
    end

    st_eff = state_d;

    if (tick && state_q != StIdle) begin
      phase_d = phase_q + 2'd1;
      case (st_eff)
        StStart: begin
          if (phase_q == 2'd0) begin
            sda_oe_d = 1'b1;
          end else begin
            scl_oe_d = 1'b1;
            phase_d  = 2'd0;
            state_d  = StWrBit;
          end
        end
        StWrBit: begin
          case (phase_q)
            2'd0: sda_oe_d = ~shreg_d[7];
            2'd1: scl_oe_d = 1'b0;
            2'd3: begin
              scl_oe_d = 1'b1;
              shreg_d  = {shreg_q[6:0], 1'b0};
              if (bit_cnt_q == 3'd7) begin
                bit_cnt_d = 3'd0;
                state_d   = StWrAck;
              end else begin
                bit_cnt_d = bit_cnt_q + 3'd1;
              end
            end
            default: ;
          endcase
        end
        StWrAck: begin
          case (phase_q)
            2'd0: sda_oe_d = 1'b0;
            2'd1: scl_oe_d = 1'b0;
            2'd2: sda_s_d  = sda_in;
            default: begin
              scl_oe_d         = 1'b1;
              ack_d[ACK_VALID] = 1'b1;
              ack_d[ACK_OK]    = ~sda_s_q;
            end
          endcase
        end
        StRdBit: begin
          case (phase_q)
            2'd0: sda_oe_d = 1'b0;
            2'd1: scl_oe_d = 1'b0;
            2'd2: shreg_d  = {shreg_q[6:0], sda_in};
            default: begin
              scl_oe_d = 1'b1;
              if (bit_cnt_q == 3'd7) begin
                bit_cnt_d = 3'd0;
                rd_data_d = shreg_q;
                rd_tick_d = 1'b1;
              end else begin
                bit_cnt_d = bit_cnt_q + 3'd1;
              end
            end
          endcase
        end
        StRdAck: begin
          case (phase_q)
            2'd0: sda_oe_d = ~nack_d;
            2'd1: scl_oe_d = 1'b0;
            2'd3: begin
              scl_oe_d = 1'b1;
              state_d  = nack_d ? StStop : StRdBit;
            end
            default: ;
          endcase
        end
        StStop: begin
          case (phase_q)
            2'd0: sda_oe_d = 1'b1;
            2'd1: scl_oe_d = 1'b0;
            default: begin
              sda_oe_d = 1'b0;
              phase_d  = 2'd0;
              state_d  = StHold;
            end
          endcase
        end
        StHold: begin
          if (phase_q == 2'd3) begin
            state_d = StIdle;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      phase_q   <= 2'd0;
      bit_cnt_q <= 3'd0;
      shreg_q   <= 8'd0;
      rw_q      <= 1'b0;
      addr_q    <= 1'b0;
      nack_q    <= 1'b0;
      sda_s_q   <= 1'b0;
      scl_oe_q  <= 1'b0;
      sda_oe_q  <= 1'b0;
      ack_q     <= 2'b00;
      rd_tick_q <= 1'b0;
      rd_data_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      rw_q      <= rw_d;
      addr_q    <= addr_d;
      nack_q    <= nack_d;
      sda_s_q   <= sda_s_d;
      scl_oe_q  <= scl_oe_d;
      sda_oe_q  <= sda_oe_d;
      ack_q     <= ack_d;
      rd_tick_q <= rd_tick_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign scl     = scl_oe_q ? 1'b0 : 1'bz;
  assign sda     = sda_oe_q ? 1'b0 : 1'bz;
  assign state   = state_q;
  assign ack     = ack_q;
  assign rd_tick = rd_tick_q;
  assign rd_data = rd_data_q;

endmodule

// File: tb/tb_i2c_master.sv
// Directed bench for i2c_master with Q=4 and a clock-sampled SCCB slave model on the bus.
module tb_i2c_master;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       rd_tick;
  logic [1:0] ack;
  logic [7:0] rd_data;
  logic [3:0] state;
  wire        scl;
  wire        sda;

  pullup (scl);
  pullup (sda);

  i2c_master #(
    .main_clock (1600),
    .freq       (100)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .stop    (stop),
    .wr_data (wr_data),
    .rd_tick (rd_tick),
    .ack     (ack),
    .rd_data (rd_data),
    .scl     (scl),
    .sda     (sda),
    .state   (state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave model state
  logic       sl_oe = 1'b0;
  logic       ack_en = 1'b1;
  logic [7:0] tx_byte = 8'hA5;
  logic       scl_p = 1'b1, sda_p = 1'b1;
  logic [7:0] rx_sr = 8'h00;
  logic [7:0] rx_bytes [8];
  int         rx_cnt = 0, sb = 0, start_cnt = 0, stop_cnt = 0;
  int         t_stop = 0, bus_free = 0, start_fall = 0, last_fall = 0, scl_per = 0;
  bit         active = 0, fall_pending = 0, slave_tx = 0, in_addr = 0, done = 0;
  logic       mack = 1'b0;

  assign sda = sl_oe ? 1'b0 : 1'bz;

  always @(negedge clk) begin
    logic scl_v, sda_v;
    scl_v = scl;
    sda_v = sda;
    if (scl_p && scl_v && sda_p && !sda_v) begin
      start_cnt++;
      bus_free = cyc - t_stop;
      sb = 0; rx_cnt = 0; slave_tx = 0; in_addr = 1; done = 0;
      active = 1; fall_pending = 1; sl_oe = 1'b0;
    end else if (scl_p && scl_v && !sda_p && sda_v) begin
      stop_cnt++;
      t_stop = cyc;
      active = 0;
      sl_oe = 1'b0;
    end else if (active && !scl_p && scl_v) begin
      if (sb < 8) rx_sr = {rx_sr[6:0], sda_v};
      else if (slave_tx) mack = sda_v;
    end else if (active && scl_p && !scl_v) begin
      scl_per = cyc - last_fall;
      last_fall = cyc;
      if (fall_pending) begin
        fall_pending = 0;
        start_fall = cyc;
      end else if (sb == 8) begin
        sb = 0;
        if (!slave_tx) begin
          if (rx_cnt < 8) rx_bytes[rx_cnt] = rx_sr;
          rx_cnt++;
          if (in_addr && rx_sr[0]) slave_tx = 1;
          in_addr = 0;
        end else if (mack) begin
          done = 1;
        end
      end else begin
        sb++;
      end
      if (done || fall_pending) sl_oe = 1'b0;
      else if (sb == 8) sl_oe = !slave_tx && ack_en;
      else if (slave_tx) sl_oe = !tx_byte[7-sb];
      else sl_oe = 1'b0;
    end
    scl_p = scl_v;
    sda_p = sda_v;
  end

  int n_chk = 0, n_pass = 0;
  int t_go = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic pulse_start(input logic [7:0] d);
    @(negedge clk);
    wr_data = d;
    start = 1'b1;
    t_go = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_ack(output logic [1:0] a);
    bit found = 0;
    a = 2'bxx;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (ack[1]) begin
        a = ack;
        found = 1;
      end
    end
  endtask

  // Waits for the ack pulse, then presents the next byte and stop alongside it.
  task automatic ack_step(input string tag, input logic [1:0] exp, input logic [7:0] nxt,
                          input logic stp);
    logic [1:0] a;
    wait_ack(a);
    check(tag, a, exp);
    wr_data = nxt;
    stop = stp;
    @(negedge clk);
    stop = 1'b0;
  endtask

  task automatic wait_idle(output logic [3:0] s);
    bit found = 0;
    s = state;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      s = state;
      if (state == 4'd0) found = 1;
    end
  endtask

  task automatic wait_rd(output bit f);
    f = 0;
    for (int i = 0; i < 400 && !f; i++) begin
      @(negedge clk);
      if (rd_tick) f = 1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] s;
    bit         f;

    repeat (3) @(negedge clk);
    check("rst_state", state, 0);
    check("rst_ack", ack, 0);
    check("rst_rd_tick", rd_tick, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_scl", scl, 1);
    check("rst_sda", sda, 1);
    rst_n = 1'b1;
    @(negedge clk);

    // Three-byte write, all ACKed
    pulse_start(8'h42);
    ack_step("wr_ack_addr", 2'b11, 8'h12, 1'b0);
    check("first_scl_fall", (start_fall - t_go) <= 10, 1);
    ack_step("wr_ack_d1", 2'b11, 8'h80, 1'b0);
    ack_step("wr_ack_d2", 2'b11, 8'h00, 1'b1);
    check("scl_period", scl_per, 16);
    wait_idle(s);
    check("wr_idle", s, 0);
    check("wr_nbytes", rx_cnt, 3);
    check("wr_byte0", rx_bytes[0], 8'h42);
    check("wr_byte1", rx_bytes[1], 8'h12);
    check("wr_byte2", rx_bytes[2], 8'h80);
    check("wr_stop", stop_cnt, 1);

    // Back-to-back, slave NACKs everything; transfer continues
    ack_en = 1'b0;
    pulse_start(8'h42);
    ack_step("nack_addr", 2'b10, 8'h55, 1'b0);
    check("bus_free", bus_free >= 16, 1);
    check("restart_seen", start_cnt, 2);
    ack_step("nack_data", 2'b10, 8'h00, 1'b1);
    wait_idle(s);
    check("nack_idle", s, 0);
    check("nack_nbytes", rx_cnt, 2);
    check("nack_byte1", rx_bytes[1], 8'h55);
    check("nack_stop", stop_cnt, 2);

    // NACKed address with stop: no further bytes
    pulse_start(8'h42);
    ack_step("nack_addr_stop", 2'b10, 8'h00, 1'b1);
    wait_idle(s);
    check("nack_stop_nbytes", rx_cnt, 1);
    check("nack_stop_stop", stop_cnt, 3);

    // Read one byte, stop in the rd_tick cycle -> master NACK then STOP
    ack_en = 1'b1;
    pulse_start(8'h43);
    ack_step("rd_ack_addr", 2'b11, 8'h00, 1'b0);
    wait_rd(f);
    check("rd_tick_seen", f, 1);
    check("rd_data", rd_data, 8'hA5);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("rd_tick_pulse", rd_tick, 0);
    wait_idle(s);
    check("rd_idle", s, 0);
    check("rd_master_nack", mack, 1);
    check("rd_stop", stop_cnt, 4);

    // start while a byte is in flight is ignored
    pulse_start(8'h42);
    repeat (40) @(negedge clk);
    wr_data = 8'hFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ack_step("busy_ack_addr", 2'b11, 8'h12, 1'b0);
    ack_step("busy_ack_d", 2'b11, 8'h00, 1'b1);
    wait_idle(s);
    check("busy_nbytes", rx_cnt, 2);
    check("busy_byte0", rx_bytes[0], 8'h42);
    check("busy_byte1", rx_bytes[1], 8'h12);
    check("busy_starts", start_cnt, 5);

    // Reset in the middle of bit 4 of the address byte
    pulse_start(8'h42);
    for (int i = 0; i < 400 && sb != 3; i++) @(negedge clk);
    check("bit4_reached", sb, 3);
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_state", state, 0);
    check("mid_rst_scl", scl, 1);
    check("mid_rst_sda", sda, 1);
    check("mid_rst_ack", ack, 0);
    check("mid_rst_rd_tick", rd_tick, 0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
